// File: rtl/conv_kxk_mac_acc_vec.sv
// OC_PAR-lane KxK convolution MAC: per-beat dot products (stage P) accumulated over input
// channels (stage A), with a bias-seeded group sum emitted once per in_first..in_last group.
module conv_kxk_mac_acc_vec #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int OC_PAR = 4,
    parameter int K      = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_first,
    input  logic                            in_last,
    input  logic [K*K*DATA_W-1:0]           window_flat,
    input  logic [OC_PAR*K*K*DATA_W-1:0]    weight_flat_vec,
    input  logic [OC_PAR*ACC_W-1:0]         bias_vec,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [OC_PAR*ACC_W-1:0]         out_acc_vec
);

    localparam int NE = K * K;
    localparam int XW = ACC_W - DATA_W;

    function automatic logic [ACC_W-1:0] sext(input logic [DATA_W-1:0] v);
        return {{XW{v[DATA_W-1]}}, v};
    endfunction

    logic                            r_p_valid;
    logic                            r_p_first;
    logic                            r_p_last;
    logic [ACC_W-1:0]                r_p_dot  [OC_PAR];
    logic [ACC_W-1:0]                r_p_bias [OC_PAR];
    logic [ACC_W-1:0]                r_acc    [OC_PAR];
    logic                            r_out_valid;
    logic [OC_PAR*ACC_W-1:0]         r_out_acc;

    logic [ACC_W-1:0]                w_dot [OC_PAR];
    logic [OC_PAR-1:0][ACC_W-1:0]    w_acc_next;
    logic                            w_out_free;
    logic                            w_p_adv;
    logic                            w_in_fire;
    logic                            w_out_load;

    // Low ACC_W bits of a product are the same signed or unsigned, so sign-extended
    // operands multiplied at ACC_W give the wrapped signed result directly.
    always_comb begin
        for (int l = 0; l < OC_PAR; l++) begin
            // NOTE: blocking assignments here are correct; this is a combinational running sum.
            w_dot[l] = '0;
            for (int e = 0; e < NE; e++) begin
                w_dot[l] = w_dot[l] + sext(window_flat[e*DATA_W +: DATA_W])
                                    * sext(weight_flat_vec[(l*NE+e)*DATA_W +: DATA_W]);
            end
        end
    end

    always_comb begin
        for (int l = 0; l < OC_PAR; l++) begin
            w_acc_next[l] = (r_p_first ? r_p_bias[l] : r_acc[l]) + r_p_dot[l];
        end
    end

    assign w_out_free = !r_out_valid || out_ready;
    assign w_p_adv    = r_p_valid && (!r_p_last || w_out_free);
    assign in_ready   = !r_p_valid || w_p_adv;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_load = w_p_adv && r_p_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_valid   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
            for (int l = 0; l < OC_PAR; l++) r_acc[l] <= '0;
        end else begin
            if (w_in_fire)    r_p_valid <= 1'b1;
            else if (w_p_adv) r_p_valid <= 1'b0;

            if (w_p_adv) begin
                for (int l = 0; l < OC_PAR; l++) r_acc[l] <= w_acc_next[l];
            end

            if (w_out_load) begin
                r_out_valid <= 1'b1;
                r_out_acc   <= w_acc_next;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
                r_out_acc   <= '0;
            end
        end
    end

    // NOTE: stage-P payload is qualified by r_p_valid, so it needs no reset and lives in
    // its own reset-free process rather than being mixed into the async-reset block above.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_p_first <= in_first;
            r_p_last  <= in_last;
            for (int l = 0; l < OC_PAR; l++) begin
                r_p_dot[l] <= w_dot[l];
                if (in_first) r_p_bias[l] <= bias_vec[l*ACC_W +: ACC_W];
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_acc_vec = r_out_acc;

endmodule

// File: tb/tb_conv_kxk_mac_acc_vec.sv
// Bench for conv_kxk_mac_acc_vec: directed boundary cases plus randomized groups, checked
// against a group-level arithmetic model; a 16-bit-accumulator instance checks wraparound.
module tb_conv_kxk_mac_acc_vec;

    localparam int DW = 8;
    localparam int AW = 32;
    localparam int NL = 4;
    localparam int KK = 3;
    localparam int NE = KK * KK;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_first = 1'b0;
    logic                 in_last = 1'b0;
    logic [NE*DW-1:0]     window_flat = '0;
    logic [NL*NE*DW-1:0]  weight_flat_vec = '0;
    logic [NL*AW-1:0]     bias_vec = '0;
    logic [NL*16-1:0]     bias16 = '0;
    logic                 out_ready = 1'b1;
    logic                 in_ready, out_valid, in_ready16, out_valid16;
    logic [NL*AW-1:0]     out_acc_vec;
    logic [NL*16-1:0]     out_acc16;

    always #5 clk = ~clk;

    conv_kxk_mac_acc_vec #(.DATA_W(DW), .ACC_W(AW), .OC_PAR(NL), .K(KK)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_first(in_first), .in_last(in_last), .window_flat(window_flat),
        .weight_flat_vec(weight_flat_vec), .bias_vec(bias_vec), .out_valid(out_valid),
        .out_ready(out_ready), .out_acc_vec(out_acc_vec)
    );

    conv_kxk_mac_acc_vec #(.DATA_W(DW), .ACC_W(16), .OC_PAR(NL), .K(KK)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
        .in_first(in_first), .in_last(in_last), .window_flat(window_flat),
        .weight_flat_vec(weight_flat_vec), .bias_vec(bias16), .out_valid(out_valid16),
        .out_ready(out_ready), .out_acc_vec(out_acc16)
    );

    int               n_vec = 0;
    int               n_err = 0;
    int               n_res = 0;
    int               ready_mode = 0;   // 0: always ready, 1: random, 2: never ready
    int               m_acc [NL];
    logic [NL*AW-1:0] exp_q [$];
    bit               st_prev = 1'b0;
    logic [NL*AW-1:0] st_val;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    function automatic int dot_of(input int l);
        int s = 0;
        for (int e = 0; e < NE; e++)
            s += int'($signed(window_flat[e*DW +: DW])) * int'($signed(weight_flat_vec[(l*NE+e)*DW +: DW]));
        return s;
    endfunction

    task automatic model_beat(input bit f, input bit l);
        logic [NL*AW-1:0] r;
        for (int i = 0; i < NL; i++) begin
            if (f) m_acc[i] = int'(bias_vec[i*AW +: AW]) + dot_of(i);
            else   m_acc[i] = m_acc[i] + dot_of(i);
            r[i*AW +: AW] = m_acc[i];
        end
        if (l) exp_q.push_back(r);
    endtask

    task automatic set_bias_all(input int v);
        for (int i = 0; i < NL; i++) begin
            bias_vec[i*AW +: AW] = v;
            bias16[i*16 +: 16]   = v[15:0];
        end
    endtask

    task automatic set_win_all(input int v);
        for (int e = 0; e < NE; e++) window_flat[e*DW +: DW] = v[DW-1:0];
    endtask

    task automatic set_w_lane(input int l, input int v);
        for (int e = 0; e < NE; e++) weight_flat_vec[(l*NE+e)*DW +: DW] = v[DW-1:0];
    endtask

    task automatic set_random();
        for (int e = 0; e < NE; e++) window_flat[e*DW +: DW] = DW'($urandom);
        for (int e = 0; e < NL*NE; e++) weight_flat_vec[e*DW +: DW] = DW'($urandom);
        for (int i = 0; i < NL; i++) begin
            bias_vec[i*AW +: AW] = $urandom;
            bias16[i*16 +: 16]   = bias_vec[i*AW +: 16];
        end
    endtask

    // One cycle: called at a falling edge, drives inputs, observes before the rising edge.
    task automatic step(input bit v, input bit f, input bit l, output bit acc_o);
        logic [NL*AW-1:0] e;
        in_valid = v; in_first = f; in_last = l;
        out_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
        #1;
        if (st_prev) begin
            check("hold_valid", 32'(out_valid), 1);
            for (int i = 0; i < NL; i++)
                check($sformatf("hold_lane%0d", i), out_acc_vec[i*AW +: AW], st_val[i*AW +: AW]);
        end
        acc_o = v && in_ready;
        if (out_valid && out_ready) begin
            n_res++;
            check("result_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("valid16", 32'(out_valid16), 1);
                for (int i = 0; i < NL; i++) begin
                    check($sformatf("lane%0d", i), out_acc_vec[i*AW +: AW], e[i*AW +: AW]);
                    check($sformatf("lane16_%0d", i), 32'(out_acc16[i*16 +: 16]), 32'(e[i*AW +: 16]));
                end
            end
        end
        if (acc_o) model_beat(f, l);
        st_prev = out_valid && !out_ready;
        st_val  = out_acc_vec;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_beat(input bit f, input bit l);
        bit a = 1'b0;
        for (int c = 0; c < 60 && !a; c++) step(1'b1, f, l, a);
        check("beat_accepted", 32'(a), 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int c = 0; c < n; c++) step(1'b0, 1'b0, 1'b0, a);
    endtask

    task automatic drain();
        bit a;
        ready_mode = 0;
        for (int c = 0; c < 30 && (exp_q.size() != 0 || out_valid); c++) step(1'b0, 1'b0, 1'b0, a);
        check("drained", 32'(exp_q.size()), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_valid16", 32'(out_valid16), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        for (int i = 0; i < NL; i++) begin
            check($sformatf("rst_lane%0d", i), out_acc_vec[i*AW +: AW], 0);
            m_acc[i] = 0;
        end
        exp_q.delete();
        st_prev = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        bit a;
        @(negedge clk);
        do_reset();

        // Single-beat group, checked for value and two-edge latency.
        set_win_all(1);
        for (int i = 0; i < NL; i++) set_w_lane(i, i + 1);
        set_bias_all(10);
        send_beat(1'b1, 1'b1);
        check("t1_not_yet", 32'(out_valid), 0);
        idle(1);
        check("t1_valid", 32'(out_valid), 1);
        for (int i = 0; i < NL; i++)
            check($sformatf("t1_lane%0d", i), out_acc_vec[i*AW +: AW], 32'(9 * (i + 1) + 10));
        drain();

        // Three-channel group, one result pulse.
        set_win_all(2);
        for (int i = 0; i < NL; i++) set_w_lane(i, -1);
        set_bias_all(0);
        r0 = n_res;
        send_beat(1'b1, 1'b0);
        send_beat(1'b0, 1'b0);
        send_beat(1'b0, 1'b1);
        idle(1);
        check("t2_lane0", out_acc_vec[AW-1:0], 32'(-54));
        drain();
        check("t2_pulses", 32'(n_res - r0), 1);

        // Output stall: back-to-back single-beat groups must back up into in_ready.
        ready_mode = 2;
        set_random();
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 1'b1, 1'b1, a);
            if (a) set_random();
        end
        check("t3_in_ready_low", 32'(in_ready), 0);
        in_valid = 1'b0;
        drain();

        // Extremes: 4 channels of -128*-128; the 16-bit instance wraps to 0.
        set_win_all(-128);
        for (int i = 0; i < NL; i++) set_w_lane(i, -128);
        set_bias_all(0);
        send_beat(1'b1, 1'b0);
        send_beat(1'b0, 1'b0);
        send_beat(1'b0, 1'b0);
        send_beat(1'b0, 1'b1);
        idle(1);
        for (int i = 0; i < NL; i++) begin
            check($sformatf("t4_lane%0d", i), out_acc_vec[i*AW +: AW], 32'd589824);
            check($sformatf("t4_wrap%0d", i), 32'(out_acc16[i*16 +: 16]), 0);
        end
        drain();

        // Mid-group restart drops the partial sum.
        set_win_all(0);
        window_flat[DW-1:0] = 8'd5;
        for (int i = 0; i < NL; i++) set_w_lane(i, 1);
        set_bias_all(1);
        send_beat(1'b1, 1'b0);
        send_beat(1'b0, 1'b0);
        window_flat[DW-1:0] = 8'd7;
        send_beat(1'b1, 1'b1);
        idle(1);
        for (int i = 0; i < NL; i++)
            check($sformatf("t5_lane%0d", i), out_acc_vec[i*AW +: AW], 32'd8);
        drain();

        // Reset mid-group with a stalled result pending, then a clean group.
        ready_mode = 2;
        set_random();
        send_beat(1'b1, 1'b1);
        idle(1);
        set_random();
        send_beat(1'b1, 1'b0);
        set_random();
        send_beat(1'b0, 1'b0);
        do_reset();
        ready_mode = 0;
        for (int b = 0; b < 3; b++) begin
            set_random();
            send_beat(b == 0, b == 2);
        end
        drain();

        // Randomized groups with random backpressure and input gaps.
        ready_mode = 1;
        for (int g = 0; g < 250; g++) begin
            int len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                set_random();
                send_beat(b == 0, b == len - 1);
                if ($urandom_range(0, 7) == 0) idle(1);
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
